// File: rtl/pkg_dtypes.sv
// Shared data types for the execution unit: address/data words and the
// operand-fetch FSM state encoding.
package pkg_dtypes;

  localparam int EXEC_UNIT_ADDR_W = 8;
  localparam int EXEC_UNIT_DATA_W = 32;

  typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

  localparam type_exec_unit_addr ADDR_ZERO = 8'h00;
  localparam type_exec_unit_data DATA_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_A  = 3'd1,
    WAIT_A = 3'd2,
    REQ_B  = 3'd3,
    WAIT_B = 3'd4,
    DONE   = 3'd5
  } type_opfetch_state;

  // True in the states that issue an xbuf request.
  function automatic logic is_req_state(input type_opfetch_state s);
    return (s == REQ_A) || (s == REQ_B);
  endfunction

endpackage

// File: rtl/counter_JK.sv
// Saturating retry counter: K clears (wins over J), J increments.
module counter_JK #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             j_i,
  input  logic             k_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (k_i) begin
      cnt_d = CNT_ZERO;
    end else if (j_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eu_operand_fetch.sv
// Operand fetch for the execution unit: accepts an instruction, reads
// operand A (and B when needed) from the xbuf with retries, and presents
// both operands to the ALU with a valid/ready handshake.
// Optional feature macro: EU_OPFETCH_TIMEOUT_EN -- when defined, a miss at
// the maximum retry count drops the instruction and pulses timeout_o;
// otherwise retries continue forever and timeout_o stays 0.
module eu_operand_fetch
  import pkg_dtypes::*;
#(
  parameter int RETRY_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  type_exec_unit_addr instr_addr_a_i,
  input  type_exec_unit_addr instr_addr_b_i,
  input  logic               instr_uses_b_i,
  output type_exec_unit_addr req_addr_o,
  output logic               req_valid_o,
  input  type_exec_unit_data resp_data_i,
  input  logic               resp_success_i,
  output logic               op_valid_o,
  input  logic               op_ready_i,
  output type_exec_unit_data op_a_o,
  output type_exec_unit_data op_b_o,
  output logic               timeout_o
);

`ifdef EU_OPFETCH_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = {RETRY_WIDTH{1'b1}};

  type_opfetch_state  state_d, state_q;
  type_exec_unit_addr addr_a_d, addr_a_q;
  type_exec_unit_addr addr_b_d, addr_b_q;
  logic               uses_b_d, uses_b_q;
  type_exec_unit_addr req_addr_d, req_addr_q;
  type_exec_unit_data op_a_d, op_a_q;
  type_exec_unit_data op_b_d, op_b_q;
  logic               timeout_d, timeout_q;

  logic                   retry_clr_s;
  logic                   retry_inc_s;
  logic [RETRY_WIDTH-1:0] retry_cnt_s;
  logic                   retry_max_s;

  counter_JK #(
    .WIDTH (RETRY_WIDTH)
  ) u_retry_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .j_i   (retry_inc_s),
    .k_i   (retry_clr_s),
    .cnt_o (retry_cnt_s)
  );

  assign retry_max_s = (retry_cnt_s == RETRY_MAX);

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    uses_b_d    = uses_b_q;
    req_addr_d  = req_addr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    timeout_d   = 1'b0;
    retry_clr_s = 1'b0;
    retry_inc_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          addr_a_d    = instr_addr_a_i;
          addr_b_d    = instr_addr_b_i;
          uses_b_d    = instr_uses_b_i;
          req_addr_d  = instr_addr_a_i;
          op_b_d      = DATA_ZERO;  // stays zero for single-operand instructions
          retry_clr_s = 1'b1;
          state_d     = REQ_A;
        end else begin
          state_d = IDLE;
        end
      end
      REQ_A: begin
        state_d = WAIT_A;
      end
      WAIT_A: begin
        if (resp_success_i) begin
          op_a_d = resp_data_i;
          if (uses_b_q) begin
            if (addr_a_q == addr_b_q) begin
              // The entry is now marked read; a second fetch would never hit.
              op_b_d  = resp_data_i;
              state_d = DONE;
            end else begin
              req_addr_d  = addr_b_q;
              retry_clr_s = 1'b1;
              state_d     = REQ_B;
            end
          end else begin
            state_d = DONE;
          end
        end else if (TIMEOUT_EN && retry_max_s) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          retry_inc_s = 1'b1;
          state_d     = REQ_A;
        end
      end
      REQ_B: begin
        state_d = WAIT_B;
      end
      WAIT_B: begin
        if (resp_success_i) begin
          op_b_d  = resp_data_i;
          state_d = DONE;
        end else if (TIMEOUT_EN && retry_max_s) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          retry_inc_s = 1'b1;
          state_d     = REQ_B;
        end
      end
      DONE: begin
        if (op_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_a_q   <= ADDR_ZERO;
      addr_b_q   <= ADDR_ZERO;
      uses_b_q   <= 1'b0;
      req_addr_q <= ADDR_ZERO;
      op_a_q     <= DATA_ZERO;
      op_b_q     <= DATA_ZERO;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      uses_b_q   <= uses_b_d;
      req_addr_q <= req_addr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      timeout_q  <= timeout_d;
    end
  end

  assign instr_ready_o = (state_q == IDLE);
  assign req_valid_o   = is_req_state(state_q);
  assign op_valid_o    = (state_q == DONE);
  assign req_addr_o    = req_addr_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_eu_operand_fetch.sv
// Self-checking bench for eu_operand_fetch with a behavioural xbuf model.
module tb_eu_operand_fetch;
  import pkg_dtypes::*;

`ifdef EU_OPFETCH_TIMEOUT_EN
  localparam int RW = 2;
`else
  localparam int RW = 4;
`endif

  logic               clk;
  logic               reset_n;
  logic               instr_valid_i;
  logic               instr_ready_o;
  type_exec_unit_addr instr_addr_a_i;
  type_exec_unit_addr instr_addr_b_i;
  logic               instr_uses_b_i;
  type_exec_unit_addr req_addr_o;
  logic               req_valid_o;
  type_exec_unit_data resp_data_i;
  logic               resp_success_i;
  logic               op_valid_o;
  logic               op_ready_i;
  type_exec_unit_data op_a_o;
  type_exec_unit_data op_b_o;
  logic               timeout_o;

  eu_operand_fetch #(.RETRY_WIDTH(RW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_valid_i  (instr_valid_i),
    .instr_ready_o  (instr_ready_o),
    .instr_addr_a_i (instr_addr_a_i),
    .instr_addr_b_i (instr_addr_b_i),
    .instr_uses_b_i (instr_uses_b_i),
    .req_addr_o     (req_addr_o),
    .req_valid_o    (req_valid_o),
    .resp_data_i    (resp_data_i),
    .resp_success_i (resp_success_i),
    .op_valid_o     (op_valid_o),
    .op_ready_i     (op_ready_i),
    .op_a_o         (op_a_o),
    .op_b_o         (op_b_o),
    .timeout_o      (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // xbuf model: per-entry data, number of misses still to serve, read flag.
  type_exec_unit_data mem [256];
  int                 miss_left [256];
  bit                 rd [256];
  bit                 pend_ok = 1'b0;
  type_exec_unit_data pend_data = 32'h0;

  typedef struct {
    type_exec_unit_addr a;
    type_exec_unit_addr b;
    logic               uses_b;
    int                 ma;
    int                 mb;
    type_exec_unit_data da;
    type_exec_unit_data db;
    int                 hold;
    type_exec_unit_data exp_a;
    type_exec_unit_data exp_b;
    int                 exp_reqs;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // xbuf responder: answers a request seen in one cycle during the next cycle.
  initial begin
    resp_success_i = 1'b0;
    resp_data_i    = 32'h0;
    forever begin
      @(negedge clk);
      resp_success_i = pend_ok;
      resp_data_i    = pend_data;
      if (req_valid_o) begin
        if (!rd[req_addr_o] && miss_left[req_addr_o] == 0) begin
          pend_ok   = 1'b1;
          pend_data = mem[req_addr_o];
          rd[req_addr_o] = 1'b1;
        end else begin
          if (miss_left[req_addr_o] > 0) miss_left[req_addr_o]--;
          pend_ok   = 1'b0;
          pend_data = $urandom;
        end
      end else begin
        pend_ok   = 1'b0;
        pend_data = $urandom;
      end
    end
  end

  task automatic load_xbuf(input vec_t v);
    mem[v.a] = v.da; miss_left[v.a] = v.ma; rd[v.a] = 1'b0;
    if (v.uses_b && v.b != v.a) begin
      mem[v.b] = v.db; miss_left[v.b] = v.mb; rd[v.b] = 1'b0;
    end
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    int reqs;
    bit done;
    bit to_seen;
    bit both;
    load_xbuf(v);
    @(negedge clk);
    chk("instr_ready_before", instr_ready_o, 1'b1);
    instr_valid_i  = 1'b1;
    instr_addr_a_i = v.a;
    instr_addr_b_i = v.b;
    instr_uses_b_i = v.uses_b;
    cyc = 0; reqs = 0; done = 1'b0; to_seen = 1'b0; both = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      instr_valid_i = 1'b0;
      if (timeout_o) to_seen = 1'b1;
      if (req_valid_o && op_valid_o) both = 1'b1;
      if (req_valid_o) begin
        chk("req_cycle", cyc, 2 * reqs + 1);
        reqs++;
      end
      if (op_valid_o) done = 1'b1;
    end
    chk("op_valid_reached", done, 1'b1);
    chk("done_cycle", cyc, 2 * v.exp_reqs + 1);
    chk("req_count", reqs, v.exp_reqs);
    chk("op_a", op_a_o, v.exp_a);
    chk("op_b", op_b_o, v.exp_b);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (timeout_o) to_seen = 1'b1;
      chk("hold_valid", op_valid_o, 1'b1);
      chk("hold_op_a", op_a_o, v.exp_a);
      chk("hold_op_b", op_b_o, v.exp_b);
    end
    op_ready_i = 1'b1;
    @(negedge clk);
    op_ready_i = 1'b0;
    chk("idle_after_ready", instr_ready_o, 1'b1);
    chk("op_valid_dropped", op_valid_o, 1'b0);
    chk("req_and_op_overlap", both, 1'b0);
    chk("no_timeout", to_seen, 1'b0);
  endtask

  initial begin
    vec_t v;
    int   reqs;
    int   pulses;
    bit   ready_at_pulse;
    bit   opv_seen;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0; miss_left[i] = 0; rd[i] = 1'b0;
    end
    reset_n = 1'b0;
    instr_valid_i = 1'b0; instr_addr_a_i = 8'h00; instr_addr_b_i = 8'h00;
    instr_uses_b_i = 1'b0; op_ready_i = 1'b0;

    // a, b, uses_b, ma, mb, da, db, hold, exp_a, exp_b, exp_reqs
    tbl[0] = '{8'h03, 8'h00, 1'b0, 0, 0, 32'hA5A5_0003, 32'h0, 0, 32'hA5A5_0003, 32'h0, 1};
    tbl[1] = '{8'h01, 8'h02, 1'b1, 0, 0, 32'h1111_0001, 32'h2222_0002, 4, 32'h1111_0001, 32'h2222_0002, 2};
    tbl[2] = '{8'h07, 8'h00, 1'b0, 3, 0, 32'h7777_0007, 32'h0, 1, 32'h7777_0007, 32'h0, 4};
    tbl[3] = '{8'h05, 8'h05, 1'b1, 0, 0, 32'h5555_0005, 32'h0, 2, 32'h5555_0005, 32'h5555_0005, 1};
    tbl[4] = '{8'h09, 8'h0A, 1'b0, 0, 0, 32'h9999_0009, 32'hDEAD_BEEF, 0, 32'h9999_0009, 32'h0, 1};
    tbl[5] = '{8'h20, 8'h21, 1'b1, 1, 2, 32'h2020_2020, 32'h2121_2121, 1, 32'h2020_2020, 32'h2121_2121, 5};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_valid", req_valid_o, 1'b0);
    chk("rst_op_valid", op_valid_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_op_a", op_a_o, 32'h0);
    chk("rst_op_b", op_b_o, 32'h0);
    chk("rst_req_addr", req_addr_o, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", instr_ready_o, 1'b1);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Randomized transactions against the xbuf reference.
    for (int i = 0; i < 40; i++) begin
      v.a      = 8'($urandom_range(0, 63));
      v.b      = ($urandom_range(0, 3) == 0) ? v.a : 8'($urandom_range(0, 63));
      v.uses_b = 1'($urandom_range(0, 1));
      v.ma     = $urandom_range(0, 3);
      v.mb     = $urandom_range(0, 3);
      v.da     = $urandom;
      v.db     = $urandom;
      v.hold   = $urandom_range(0, 3);
      v.exp_a  = v.da;
      if (!v.uses_b)        v.exp_b = 32'h0;
      else if (v.a == v.b)  v.exp_b = v.da;
      else                  v.exp_b = v.db;
      v.exp_reqs = (v.ma + 1) + ((v.uses_b && v.a != v.b) ? (v.mb + 1) : 0);
      run_txn(v);
    end

`ifdef EU_OPFETCH_TIMEOUT_EN
    // Operand A never hits: 2**RW requests, then one timeout pulse.
    mem[8'h30] = 32'h3030_3030; miss_left[8'h30] = 1000; rd[8'h30] = 1'b0;
    @(negedge clk);
    instr_valid_i = 1'b1; instr_addr_a_i = 8'h30; instr_addr_b_i = 8'h31; instr_uses_b_i = 1'b0;
    reqs = 0; pulses = 0; ready_at_pulse = 1'b0; opv_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      instr_valid_i = 1'b0;
      if (req_valid_o) reqs++;
      if (op_valid_o) opv_seen = 1'b1;
      if (timeout_o) begin
        pulses++;
        ready_at_pulse = instr_ready_o;
      end
      if (pulses != 0 && !timeout_o) break;
    end
    chk("to_req_count", reqs, 4);
    chk("to_pulses", pulses, 1);
    chk("to_ready_at_pulse", ready_at_pulse, 1'b1);
    chk("to_ready_next", instr_ready_o, 1'b1);
    chk("to_no_op_valid", opv_seen, 1'b0);
    miss_left[8'h30] = 0;
`else
    // Retries continue past the saturated counter until the entry hits.
    v = '{8'h30, 8'h31, 1'b0, 20, 0, 32'h3030_3030, 32'h0, 0, 32'h3030_3030, 32'h0, 21};
    run_txn(v);
`endif

    // Reset while waiting on operand B drops the instruction silently.
    v = '{8'h40, 8'h41, 1'b1, 0, 0, 32'h4040_4040, 32'h4141_4141, 0, 32'h0, 32'h0, 0};
    load_xbuf(v);
    @(negedge clk);
    instr_valid_i = 1'b1; instr_addr_a_i = 8'h40; instr_addr_b_i = 8'h41; instr_uses_b_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstmid_req_valid", req_valid_o, 1'b0);
    chk("rstmid_op_valid", op_valid_o, 1'b0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (timeout_o) pulses++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (timeout_o) pulses++;
    end
    chk("rstmid_no_timeout", pulses, 0);
    chk("rstmid_ready", instr_ready_o, 1'b1);
    chk("rstmid_op_a", op_a_o, 32'h0);
    chk("rstmid_op_valid_after", op_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
